// File: rtl/instruction_memory_loader_pkg.sv
// Shared sizes and address helper for the boot-time instruction memory loader.
package instruction_memory_loader_pkg;

    localparam int INSTRUCTION_SIZE = 32;
    localparam int IMEM_DEPTH_WORDS = 256;
    localparam int COUNT_W          = 16;

    // Byte address of word `idx` counted from `base`; idx < depth so no wrap.
    function automatic logic [INSTRUCTION_SIZE-1:0] word_addr(
        input logic [INSTRUCTION_SIZE-1:0] base,
        input logic [COUNT_W-1:0]          idx
    );
        return base + {14'b0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/instruction_memory_loader_byte_to_word_packer.sv
// Packs four little-endian bytes into one instruction word; the first byte
// ends up in [7:0] and the fourth in [31:24].
module byte_to_word_packer
    import instruction_memory_loader_pkg::*;
(
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clear,
    input  logic                        byte_en,
    input  logic [7:0]                  byte_data,
    output logic                        word_full,
    output logic [INSTRUCTION_SIZE-1:0] packed_word
);

    logic [1:0]                  byte_idx;
    logic [INSTRUCTION_SIZE-1:0] shift_reg;

    // Shift right so that after four bytes the oldest byte sits at [7:0].
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_idx  <= 2'd0;
            shift_reg <= '0;
        end else if (clear) begin
            byte_idx  <= 2'd0;
            shift_reg <= '0;
        end else if (byte_en) begin
            byte_idx  <= byte_idx + 2'd1;
            shift_reg <= {byte_data, shift_reg[INSTRUCTION_SIZE-1:8]};
        end
    end

    assign word_full   = byte_en && (byte_idx == 2'd3);
    assign packed_word = shift_reg;

endmodule

// File: rtl/instruction_memory_loader.sv
// Receives a length-prefixed byte frame and writes little-endian words into
// instruction memory at consecutive addresses, holding the CPU while loading.
module instruction_memory_loader
    import instruction_memory_loader_pkg::*;
#(
    parameter logic [INSTRUCTION_SIZE-1:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned                 DEPTH_WORDS = IMEM_DEPTH_WORDS
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        Start,
    input  logic [7:0]                  ByteData,
    input  logic                        ByteValid,
    output logic                        ByteReady,
    output logic                        WriteEnable,
    output logic [INSTRUCTION_SIZE-1:0] WriteAddress,
    output logic [INSTRUCTION_SIZE-1:0] WriteData,
    output logic                        Busy,
    output logic                        CpuHold,
    output logic                        Done,
    output logic                        Error,
    output logic [COUNT_W-1:0]          WordCount,
    output logic [2:0]                  dbg_state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_LO = 3'd1,
        LEN_HI = 3'd2,
        DATA   = 3'd3,
        WRITE  = 3'd4,
        DONE   = 3'd5,
        ERROR  = 3'd6
    } state_t;

    state_t               state;
    logic [7:0]           len_lo;
    logic [COUNT_W-1:0]   frame_len;
    logic [COUNT_W-1:0]   frame_len_in;
    logic                 byte_accept;
    logic                 data_accept;
    logic                 start_accept;
    logic                 word_full;

    // Handshake: a byte moves on a rising edge where ByteValid && ByteReady;
    // ByteReady is registered and high only in LEN_LO, LEN_HI and DATA, so
    // bytes offered in any other state are left with the sender.
    assign byte_accept  = ByteValid && ByteReady;
    assign data_accept  = byte_accept && (state == DATA);
    assign start_accept = Start && !Busy;
    assign frame_len_in = {ByteData, len_lo};

    byte_to_word_packer u_packer (
        .clk         (clk),
        .reset       (reset),
        .clear       (start_accept),
        .byte_en     (data_accept),
        .byte_data   (ByteData),
        .word_full   (word_full),
        .packed_word (WriteData)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            ByteReady    <= 1'b0;
            WriteEnable  <= 1'b0;
            WriteAddress <= BASE_ADDR;
            Busy         <= 1'b0;
            Done         <= 1'b0;
            Error        <= 1'b0;
            WordCount    <= '0;
            len_lo       <= '0;
            frame_len    <= '0;
        end else begin
            case (state)
                IDLE, DONE, ERROR: begin
                    if (start_accept) begin
                        state     <= LEN_LO;
                        ByteReady <= 1'b1;
                        Busy      <= 1'b1;
                        Done      <= 1'b0;
                        Error     <= 1'b0;
                        WordCount <= '0;
                    end
                end
                LEN_LO: begin
                    if (byte_accept) begin
                        len_lo <= ByteData;
                        state  <= LEN_HI;
                    end
                end
                LEN_HI: begin
                    if (byte_accept) begin
                        frame_len <= frame_len_in;
                        if (frame_len_in == '0) begin
                            state     <= DONE;
                            ByteReady <= 1'b0;
                            Busy      <= 1'b0;
                            Done      <= 1'b1;
                        end else if ({16'b0, frame_len_in} > 32'(DEPTH_WORDS)) begin
                            state     <= ERROR;
                            ByteReady <= 1'b0;
                            Busy      <= 1'b0;
                            Error     <= 1'b1;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (word_full) begin
                        state        <= WRITE;
                        ByteReady    <= 1'b0;
                        WriteEnable  <= 1'b1;
                        WriteAddress <= word_addr(BASE_ADDR, WordCount);
                    end
                end
                WRITE: begin
                    WriteEnable <= 1'b0;
                    WordCount   <= WordCount + 16'd1;
                    if ((WordCount + 16'd1) == frame_len) begin
                        state <= DONE;
                        Busy  <= 1'b0;
                        Done  <= 1'b1;
                    end else begin
                        state     <= DATA;
                        ByteReady <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    ByteReady <= 1'b0;
                    Busy      <= 1'b0;
                end
            endcase
        end
    end

    assign CpuHold   = Busy;
    assign dbg_state = state;

endmodule

// File: tb/tb_instruction_memory_loader.sv
// Directed bench for the instruction memory loader with a write scoreboard
// and a small instruction memory model for readback.
module tb_instruction_memory_loader;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_ERROR = 3'd6;

    logic        clk;
    logic        reset;
    logic        Start;
    logic [7:0]  ByteData;
    logic        ByteValid;
    logic        ByteReady;
    logic        WriteEnable;
    logic [31:0] WriteAddress;
    logic [31:0] WriteData;
    logic        Busy;
    logic        CpuHold;
    logic        Done;
    logic        Error;
    logic [15:0] WordCount;
    logic [2:0]  dbg_state;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wr_count = 0;
    int wr_base;
    int t0;

    logic [63:0] exp_q[$];
    logic [31:0] imem[0:255];
    logic [31:0] prog[0:26];

    instruction_memory_loader dut (
        .clk          (clk),
        .reset        (reset),
        .Start        (Start),
        .ByteData     (ByteData),
        .ByteValid    (ByteValid),
        .ByteReady    (ByteReady),
        .WriteEnable  (WriteEnable),
        .WriteAddress (WriteAddress),
        .WriteData    (WriteData),
        .Busy         (Busy),
        .CpuHold      (CpuHold),
        .Done         (Done),
        .Error        (Error),
        .WordCount    (WordCount),
        .dbg_state    (dbg_state)
    );

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every write strobe must match the next expected {addr, data}
    always @(negedge clk) begin
        if (WriteEnable) begin
            logic [63:0] e;
            wr_count++;
            imem[WriteAddress[9:2]] = WriteData;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_write: observed addr 0x%08h data 0x%08h expected none",
                       WriteAddress, WriteData);
            end else begin
                e = exp_q.pop_front();
                check32("write_addr", WriteAddress, e[63:32]);
                check32("write_data", WriteData, e[31:0]);
            end
        end
    end

    // Driver tasks; all are entered and left on a falling edge
    task automatic pulse_start();
        Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int w;
        w = 0;
        ByteData  = b;
        ByteValid = 1'b1;
        while (!ByteReady && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (w >= 100) begin
            checks++;
            errors++;
            $error("FAIL byte_ready_wait: observed timeout expected ByteReady");
        end
        @(negedge clk);
    endtask

    task automatic send_byte_gap(input logic [7:0] b);
        send_byte(b);
        ByteValid = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w, input bit gap);
        for (int i = 0; i < 4; i++) begin
            if (gap) send_byte_gap(w[8*i +: 8]);
            else     send_byte(w[8*i +: 8]);
        end
    endtask

    task automatic wait_done();
        int w;
        w = 0;
        ByteValid = 1'b0;
        while (!Done && !Error && w < 400) begin
            @(negedge clk);
            w++;
        end
        if (w >= 400) begin
            checks++;
            errors++;
            $error("FAIL done_wait: observed timeout expected Done or Error");
        end
    endtask

    task automatic check_reset_values(input string tag);
        check32({tag, "_byte_ready"}, {31'b0, ByteReady}, 32'd0);
        check32({tag, "_write_enable"}, {31'b0, WriteEnable}, 32'd0);
        check32({tag, "_write_address"}, WriteAddress, 32'h0);
        check32({tag, "_write_data"}, WriteData, 32'h0);
        check32({tag, "_busy"}, {31'b0, Busy}, 32'd0);
        check32({tag, "_cpu_hold"}, {31'b0, CpuHold}, 32'd0);
        check32({tag, "_done"}, {31'b0, Done}, 32'd0);
        check32({tag, "_error"}, {31'b0, Error}, 32'd0);
        check32({tag, "_word_count"}, {16'b0, WordCount}, 32'd0);
        check32({tag, "_state"}, {29'b0, dbg_state}, {29'b0, S_IDLE});
    endtask

    initial begin
        prog[0]  = 32'h000000B7; prog[1]  = 32'h00000117; prog[2]  = 32'h00500193;
        prog[3]  = 32'h00100213; prog[4]  = 32'h00208293; prog[5]  = 32'h00310313;
        prog[6]  = 32'h00418393; prog[7]  = 32'h00520413; prog[8]  = 32'h00628493;
        prog[9]  = 32'h00730513; prog[10] = 32'h00838593; prog[11] = 32'h00940613;
        prog[12] = 32'h00A48693; prog[13] = 32'h00B50713; prog[14] = 32'h00C58793;
        prog[15] = 32'h00D60813; prog[16] = 32'h00E68893; prog[17] = 32'h00F70913;
        prog[18] = 32'h01078993; prog[19] = 32'h01180A13; prog[20] = 32'h01288A93;
        prog[21] = 32'h01390B13; prog[22] = 32'h01498B93; prog[23] = 32'h015A0C13;
        prog[24] = 32'h016A8C93; prog[25] = 32'h017B0D13; prog[26] = 32'h0000006F;

        reset = 1'b1; Start = 1'b0; ByteValid = 1'b0; ByteData = 8'h00;
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        reset = 1'b0;
        @(negedge clk);

        // Three-word frame, ByteValid held high: 17 cycles to Done
        exp_q.push_back({32'h0, 32'h000000B7});
        exp_q.push_back({32'h4, 32'h00000117});
        exp_q.push_back({32'h8, 32'h00500193});
        wr_base = wr_count;
        pulse_start();
        check32("start_busy", {31'b0, Busy}, 32'd1);
        check32("start_cpu_hold", {31'b0, CpuHold}, 32'd1);
        check32("start_byte_ready", {31'b0, ByteReady}, 32'd1);
        t0 = cyc;
        send_byte(8'h03); send_byte(8'h00);
        send_word(32'h000000B7, 1'b0);
        send_word(32'h00000117, 1'b0);
        send_word(32'h00500193, 1'b0);
        wait_done();
        check32("n3_latency", cyc - t0, 32'd17);
        check32("n3_done", {31'b0, Done}, 32'd1);
        check32("n3_error", {31'b0, Error}, 32'd0);
        check32("n3_busy", {31'b0, Busy}, 32'd0);
        check32("n3_word_count", {16'b0, WordCount}, 32'd3);
        check32("n3_writes", wr_count - wr_base, 32'd3);

        // Full 27-word program with ByteValid toggling every other cycle
        for (int i = 0; i < 27; i++) exp_q.push_back({32'(4 * i), prog[i]});
        pulse_start();
        send_byte_gap(8'd27); send_byte_gap(8'h00);
        for (int i = 0; i < 27; i++) send_word(prog[i], 1'b1);
        wait_done();
        check32("prog_done", {31'b0, Done}, 32'd1);
        check32("prog_word_count", {16'b0, WordCount}, 32'd27);
        for (int pc = 0; pc <= 104; pc += 4) check32("imem_readback", imem[pc >> 2], prog[pc >> 2]);

        // Empty frame: Done two cycles after the first length byte, no writes
        wr_base = wr_count;
        pulse_start();
        t0 = cyc;
        send_byte(8'h00); send_byte(8'h00);
        wait_done();
        check32("n0_latency", cyc - t0, 32'd2);
        check32("n0_done", {31'b0, Done}, 32'd1);
        check32("n0_word_count", {16'b0, WordCount}, 32'd0);
        check32("n0_writes", wr_count - wr_base, 32'd0);

        // Oversize frame (257 words) is rejected
        wr_base = wr_count;
        pulse_start();
        send_byte(8'h01); send_byte(8'h01);
        wait_done();
        check32("big_error", {31'b0, Error}, 32'd1);
        check32("big_done", {31'b0, Done}, 32'd0);
        check32("big_byte_ready", {31'b0, ByteReady}, 32'd0);
        check32("big_busy", {31'b0, Busy}, 32'd0);
        check32("big_state", {29'b0, dbg_state}, {29'b0, S_ERROR});
        ByteData = 8'hAA; ByteValid = 1'b1;
        repeat (3) @(negedge clk);
        ByteValid = 1'b0;
        check32("big_ignores_bytes", {29'b0, dbg_state}, {29'b0, S_ERROR});
        check32("big_writes", wr_count - wr_base, 32'd0);
        pulse_start();
        check32("big_error_cleared", {31'b0, Error}, 32'd0);
        check32("big_restart_busy", {31'b0, Busy}, 32'd1);

        // Reset after two data bytes of the first word
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22);
        ByteValid = 1'b0;
        reset = 1'b1;
        #1;
        check_reset_values("midreset");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        exp_q.push_back({32'h0, 32'h11223344});
        pulse_start();
        send_byte(8'h01); send_byte(8'h00);
        send_word(32'h11223344, 1'b0);
        wait_done();
        check32("after_reset_done", {31'b0, Done}, 32'd1);
        check32("after_reset_word_count", {16'b0, WordCount}, 32'd1);

        // Start pulsed mid-load is ignored
        exp_q.push_back({32'h0, 32'hA1B2C3D4});
        exp_q.push_back({32'h4, 32'h0EADBEEF});
        pulse_start();
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'hD4); send_byte(8'hC3);
        ByteValid = 1'b0;
        pulse_start();
        check32("mid_start_busy", {31'b0, Busy}, 32'd1);
        check32("mid_start_state", {29'b0, dbg_state}, {29'b0, S_DATA});
        check32("mid_start_word_count", {16'b0, WordCount}, 32'd0);
        send_byte(8'hB2); send_byte(8'hA1);
        send_word(32'h0EADBEEF, 1'b0);
        wait_done();
        check32("mid_start_done", {31'b0, Done}, 32'd1);
        check32("mid_start_error", {31'b0, Error}, 32'd0);
        check32("mid_start_final_count", {16'b0, WordCount}, 32'd2);

        repeat (2) @(negedge clk);
        check32("scoreboard_drained", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_memory_loader.md
# instruction_memory_loader

Boot-time programmer that receives a framed byte stream from the host link and writes little-endian 32-bit instruction words into InstructionMemory at consecutive word addresses. It is the write-side counterpart of InstructionMemory's combinational read port. It sits between the host byte receiver and the memory's write port, and holds the core in reset (CpuHold) while loading.

## Interface

Parameters:

- BASE_ADDR, 32'h0000_0000: byte address that receives the first word; must be 4-byte aligned.
- DEPTH_WORDS, 256: capacity of InstructionMemory in words; the frame length limit.

Ports:

- clk, input, 1: rising-edge clock.
- reset, input, 1: asynchronous, active-high reset.
- Start, input, 1: single-cycle pulse that begins a load.
- ByteData, input, 8: incoming stream byte.
- ByteValid, input, 1: ByteData is valid.
- ByteReady, output, 1: loader accepts a byte this cycle.
- WriteEnable, output, 1: one-cycle memory write strobe.
- WriteAddress, output, `INSTRUCTION_SIZE`: byte address of the word being written.
- WriteData, output, `INSTRUCTION_SIZE`: assembled instruction word.
- Busy, output, 1: a load is in progress.
- CpuHold, output, 1: equal to Busy.
- Done, output, 1: the last load completed; level signal.
- Error, output, 1: the last frame was rejected; level signal.
- WordCount, output, 16: number of words written in the current or last load.

## Operation

- A frame is a 16-bit word count N, sent low byte first, followed by 4·N data bytes. Each word is little-endian: the first byte of a word goes to [7:0] and the fourth to [31:24].
- A byte transfers on a rising edge where ByteValid && ByteReady.
- The FSM states are IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE, ERROR.
- IDLE / DONE / ERROR → LEN_LO when Start is high. This clears Done, Error, WordCount and the byte index.
- LEN_LO → LEN_HI when a byte is accepted.
- LEN_HI, on byte accept:
  - N = 0: go to DONE with no writes.
  - N > DEPTH_WORDS: go to ERROR with no writes.
  - Otherwise: go to DATA.
- DATA: accept bytes into the packer. The 4th accepted byte of a word moves the FSM to WRITE.
- WRITE lasts exactly one cycle:
  - WriteEnable = 1.
  - WriteAddress = BASE_ADDR + 4·WordCount.
  - WriteData = the packed word.
  - WordCount increments at the end of the cycle.
  - Next state is DONE if the new WordCount == N, else DATA.
- ByteReady = 1 only in LEN_LO, LEN_HI and DATA. It is 0 in WRITE, so no byte is lost while a write is in flight.
- Start is ignored while Busy.
- ByteValid outside LEN_LO, LEN_HI and DATA is ignored; those bytes are neither consumed nor buffered.
- Done and Error are sticky until the next Start or reset. They are never high together.
- Address arithmetic is 32-bit unsigned. The 4·WordCount term is always below 4·DEPTH_WORDS, so it cannot wrap.

## Timing

- Reset values, asynchronous: state IDLE; ByteReady, WriteEnable, Busy, CpuHold, Done and Error = 0; WriteAddress = BASE_ADDR; WriteData = 0; WordCount = 0.
- Busy rises the cycle after Start is sampled and stays high through the final WRITE cycle.
- Minimum timing with ByteValid held high:
  - Length phase: 2 cycles.
  - Each word: 4 byte cycles followed by 1 WRITE cycle.
  - Total from the first length byte to Done rising: 2 + 5N cycles.
- Done rises on the cycle after the final WriteEnable, in the same edge where Busy falls.
- WriteAddress and WriteData are registered and stable for the whole WriteEnable cycle. Memory samples them on that cycle's closing edge.
- A gap in ByteValid stalls the FSM in its current state. There is no timeout.
- Reset mid-load:
  - Returns to IDLE immediately and discards any partial word.
  - Words already written stay in memory.
  - WordCount reads 0.

## Structure

- `INSTRUCTION_SIZE` comes from the shared RISCV_PKG.vh. Add `IMEM_DEPTH_WORDS` there and use it as the default for DEPTH_WORDS.
- State encodings are localparams inside this module; they are not shared.
- One sub-module: byte_to_word_packer.
  - Contains a 2-bit byte index and a 32-bit shift-in register.
  - Asserts word_full on the 4th byte.
  - Has a clear input driven by Start and reset.

## Test plan

- Frame 03 00, then B7 00 00 00, 17 01 00 00, 93 01 50 00 → three WriteEnable pulses:
  - Address 0x0 with data 0x000000B7.
  - Address 0x4 with data 0x00000117.
  - Address 0x8 with data 0x00500193.
  - Then Done = 1, WordCount = 3, and 17 cycles from the first byte to Done.
- All 27 program words (0x000000B7 … 0x0000006F) with ByteValid toggled every other cycle → memory readback through the InstructionMemory read port at PC 0..104 matches each word; Done = 1.
- Frame 00 00 → no WriteEnable; Done = 1 two cycles after the first length byte.
- Frame 01 01 (N = 257 > 256) → Error = 1, no WriteEnable, ByteReady = 0; a later Start clears Error.
- reset asserted after 2 data bytes of word 1 → all outputs return to reset values asynchronously. A fresh 1-word frame then writes address 0x0 with only the new data.
- Start pulsed mid-load → ignored; the load completes normally with the correct WordCount.
